// File: rtl/cle_response_seq.sv
// Challenge/response sequencer for the cartridge-lock path: LFSR-driven response bits, key-sequence unlock.
// Optional idle timeout in CHAL is enabled by defining CLE_SEQ_TIMEOUT_EN.
module cle_response_seq #(
   parameter int unsigned          STATE_W     = 6,
   parameter int unsigned          ADDR_W      = 14,
   parameter logic [1:0]           WIN_HI      = 2'b01,
   parameter logic [STATE_W-1:0]   POLY        = 6'b110000,
   parameter logic [STATE_W-1:0]   SEED        = 6'b000001,
   parameter int unsigned          KEY_LEN     = 4,
   parameter logic [3:0]           START_NIB   = 4'h2,
   parameter logic [STATE_W-1:0]   OUT_MASK0   = 6'b101001,
   parameter logic [STATE_W-1:0]   OUT_MASK1   = 6'b010110,
   parameter int unsigned          TIMEOUT_CYC = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cyc,
   input  logic               sel_n,
   input  logic [ADDR_W-1:0]  addr,
   input  logic               rd_wr,
   output logic [1:0]         rd_data,
   output logic               rd_oe,
   output logic [STATE_W-1:0] state_o,
   output logic               locked
);

   localparam int unsigned CNT_W = $clog2(KEY_LEN) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_LEN - 1);

   typedef enum logic [1:0] {IDLE, CHAL, OPEN} state_t;

   state_t             state, state_nx;
   logic [STATE_W-1:0] s, s_nx, s_step;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic               qual, qrd, qwr;
   logic [3:0]         nib;

   assign qual = cyc & ~sel_n & (addr[ADDR_W-1:ADDR_W-2] == WIN_HI);
   assign qrd  = qual & rd_wr;
   assign qwr  = qual & ~rd_wr;
   assign nib  = addr[7:4];

   // An all-zero state would lock the LFSR up; recover straight to SEED.
   assign s_step = (s == '0) ? SEED : {s[STATE_W-2:0], ^(s & POLY)};

   assign rd_data = {^(s & OUT_MASK1), ^(s & OUT_MASK0)};
   assign rd_oe   = qrd;
   assign state_o = s;
   assign locked  = (state != OPEN);

`ifdef CLE_SEQ_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0] tcnt, tcnt_nx;
   logic            timeout;

   assign timeout = (state == CHAL) && !qual && (tcnt == TO_LAST);
   assign tcnt_nx = (state_nx == CHAL && !qual) ? tcnt + 1'b1 : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tcnt <= '0;
      else        tcnt <= tcnt_nx;
   end

   logic unused_bits;
   assign unused_bits = ^addr;
`else
   logic timeout;
   assign timeout = 1'b0;

   logic unused_bits;
   assign unused_bits = ^{addr, TIMEOUT_CYC};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         s     <= SEED;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         s     <= s_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      s_nx     = s;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (qrd && nib == START_NIB) begin
               state_nx = CHAL;
               s_nx     = s_step;
               cnt_nx   = '0;
            end
         end
         CHAL: begin
            if (qrd) begin
               if (nib == s[3:0]) begin
                  s_nx = s_step;
                  if (cnt == CNT_LAST) state_nx = OPEN;
                  else                 cnt_nx   = cnt + 1'b1;
               end else begin
                  state_nx = IDLE;
                  s_nx     = SEED;
                  cnt_nx   = '0;
               end
            end else if (timeout) begin
               state_nx = IDLE;
               s_nx     = SEED;
               cnt_nx   = '0;
            end
         end
         OPEN: begin
            if (qrd) begin
               s_nx = s_step;
            end else if (qwr && nib == 4'hF) begin
               state_nx = IDLE;
               s_nx     = SEED;
               cnt_nx   = '0;
            end
         end
         default: begin
            state_nx = IDLE;
            s_nx     = SEED;
            cnt_nx   = '0;
         end
      endcase
   end

endmodule
